// File: rtl/cofre_controller.sv
// Master controller for the safe: sequences open / closed / blocked, counts wrong
// attempts, times the lockout and drives the bolt and alarm.
module cofre_controller #(
   parameter int BLOCK_CYCLES = 50000000,
   parameter int CNT_W        = 26
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       B,
   input  logic       FECHA,
   input  logic       senha_ok,
   output logic [1:0] state,
   output logic [1:0] error_count,
   output logic       SPA,
   output logic       trava,
   output logic       alarme
);

   typedef enum logic [1:0] {
      AB  = 2'b00,
      FE  = 2'b01,
      BL  = 2'b10,
      ILL = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_CYCLES - 1);

   // The state register stays a plain vector so the illegal code 11 is representable.
   logic [1:0]       state_q, state_d;
   logic [1:0]       err_q, err_d;
   logic             spa_q, spa_d;
   logic             trava_q, trava_d;
   logic             alarme_q, alarme_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             b_prev;
   logic             b_rise;

   assign b_rise = B & ~b_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= AB;
         err_q    <= 2'd0;
         spa_q    <= 1'b0;
         trava_q  <= 1'b0;
         alarme_q <= 1'b0;
         cnt_q    <= '0;
         b_prev   <= 1'b0;
      end else begin
         state_q  <= state_d;
         err_q    <= err_d;
         spa_q    <= spa_d;
         trava_q  <= trava_d;
         alarme_q <= alarme_d;
         cnt_q    <= cnt_d;
         b_prev   <= B;
      end
   end

   always_comb begin
      state_d  = state_q;
      err_d    = err_q;
      spa_d    = spa_q;
      trava_d  = trava_q;
      alarme_d = alarme_q;
      cnt_d    = cnt_q;
      case (state_t'(state_q))
         AB: begin
            // Programming wins over closing when both happen in the same cycle.
            if (b_rise && !spa_q) begin
               spa_d = 1'b1;
            end else if (FECHA && spa_q) begin
               state_d = FE;
               trava_d = 1'b1;
            end
         end
         FE: begin
            if (b_rise) begin
               if (senha_ok) begin
                  state_d = AB;
                  trava_d = 1'b0;
                  err_d   = 2'd0;
                  spa_d   = 1'b0;
               end else if (err_q < 2'd2) begin
                  err_d = err_q + 2'd1;
               end else begin
                  err_d    = 2'd3;
                  state_d  = BL;
                  alarme_d = 1'b1;
                  cnt_d    = '0;
               end
            end
         end
         BL: begin
            if (cnt_q == CNT_LAST) begin
               state_d  = FE;
               err_d    = 2'd0;
               alarme_d = 1'b0;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ILL: begin
            state_d  = BL;
            err_d    = 2'd3;
            trava_d  = 1'b1;
            alarme_d = 1'b1;
            cnt_d    = '0;
         end
      endcase
   end

   always_comb begin
      state       = state_q;
      error_count = err_q;
      SPA         = spa_q;
      trava       = trava_q;
      alarme      = alarme_q;
   end

endmodule

// File: tb/tb_cofre_controller.sv
// Bench for cofre_controller: directed scenarios against fixed expectations, then
// randomized traffic against a countdown-based reference model of the safe.
module tb_cofre_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       B = 1'b0;
   logic       FECHA = 1'b0;
   logic       senha_ok = 1'b0;
   logic [1:0] state;
   logic [1:0] error_count;
   logic       SPA;
   logic       trava;
   logic       alarme;

   int vectors = 0;
   int miscompares = 0;

   logic [6:0] obs;
   logic [6:0] exp;
   logic [1:0] ill = 2'b11;

   // Reference model: open/closed/blocked with a countdown of remaining lockout cycles.
   int m_mode;
   int m_err;
   int m_armed;
   int m_bolt;
   int m_alarm;
   int m_remain;
   int m_bprev;

   cofre_controller #(.BLOCK_CYCLES(8), .CNT_W(4)) dut (
      .clk(clk),
      .reset(reset),
      .B(B),
      .FECHA(FECHA),
      .senha_ok(senha_ok),
      .state(state),
      .error_count(error_count),
      .SPA(SPA),
      .trava(trava),
      .alarme(alarme)
   );

   always #5 clk = ~clk;

   assign obs = {state, error_count, SPA, trava, alarme};

   task automatic model_step();
      int press;
      if (reset) begin
         m_mode = 0; m_err = 0; m_armed = 0; m_bolt = 0; m_alarm = 0;
         m_remain = 0; m_bprev = 0;
      end else begin
         press = (B && !m_bprev) ? 1 : 0;
         if (m_mode == 0) begin
            if (press == 1 && m_armed == 0) m_armed = 1;
            else if (FECHA && m_armed == 1) begin m_mode = 1; m_bolt = 1; end
         end else if (m_mode == 1) begin
            if (press == 1) begin
               if (senha_ok) begin
                  m_mode = 0; m_bolt = 0; m_err = 0; m_armed = 0;
               end else begin
                  m_err = m_err + 1;
                  if (m_err == 3) begin m_mode = 2; m_alarm = 1; m_remain = 8; end
               end
            end
         end else begin
            m_remain = m_remain - 1;
            if (m_remain == 0) begin m_mode = 1; m_err = 0; m_alarm = 0; end
         end
         m_bprev = B ? 1 : 0;
      end
   endtask

   task automatic tick(input logic b, input logic f, input logic ok);
      B = b; FECHA = f; senha_ok = ok;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(0, 0, 0);
      tick(0, 0, 0);
      reset = 1'b0;
      exp = 7'b0000000; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL reset: got %b want %b", obs, exp); end
   endtask

   task automatic test_program();
      tick(1, 0, 0);
      exp = 7'b0000100; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL program: got %b want %b", obs, exp); end
      tick(0, 0, 0);
      tick(1, 0, 0);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL second_press_ab: got %b want %b", obs, exp); end
      tick(0, 0, 0);
   endtask

   task automatic test_lock();
      tick(0, 1, 0);
      exp = 7'b0100110; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL lock: got %b want %b", obs, exp); end
      tick(0, 0, 0);
   endtask

   task automatic test_lockout();
      tick(1, 0, 0);
      exp = 7'b0101110; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL wrong1: got %b want %b", obs, exp); end
      tick(0, 0, 0);
      tick(1, 0, 0);
      exp = 7'b0110110; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL wrong2: got %b want %b", obs, exp); end
      tick(0, 0, 0);
      tick(1, 0, 0);
      exp = 7'b1011111; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL block_entry: got %b want %b", obs, exp); end
      // Button pressed late in the lockout and held across the exit.
      for (int i = 1; i <= 7; i++) begin
         tick((i >= 5) ? 1'b1 : 1'b0, 0, 1);
         vectors++;
         if (obs !== exp) begin miscompares++; $display("[TB] FAIL block_hold_%0d: got %b want %b", i, obs, exp); end
      end
      tick(1, 0, 0);
      exp = 7'b0100110; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL block_exit: got %b want %b", obs, exp); end
      tick(1, 0, 0);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL held_across_exit: got %b want %b", obs, exp); end
      tick(0, 0, 0);
   endtask

   task automatic test_unlock();
      tick(1, 0, 0);
      tick(0, 0, 0);
      tick(1, 0, 0);
      tick(0, 0, 0);
      exp = 7'b0110110; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL err2_before_unlock: got %b want %b", obs, exp); end
      tick(1, 0, 1);
      exp = 7'b0000000; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL unlock: got %b want %b", obs, exp); end
      tick(0, 0, 0);
   endtask

   task automatic test_hold();
      tick(1, 0, 0);
      tick(0, 0, 0);
      tick(0, 1, 0);
      for (int i = 0; i < 20; i++) tick(1, 0, 0);
      exp = 7'b0101110; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL hold20: got %b want %b", obs, exp); end
      tick(0, 0, 0);
      tick(1, 0, 1);
      exp = 7'b0000000; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL hold_unlock: got %b want %b", obs, exp); end
      tick(0, 0, 0);
   endtask

   task automatic test_fecha_unprogrammed();
      tick(0, 1, 0);
      exp = 7'b0000000; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL fecha_spa0: got %b want %b", obs, exp); end
      tick(1, 1, 0);
      exp = 7'b0000100; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL press_with_fecha: got %b want %b", obs, exp); end
      tick(0, 1, 0);
      exp = 7'b0100110; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL late_close: got %b want %b", obs, exp); end
      tick(0, 0, 0);
   endtask

   task automatic test_reset_in_lockout();
      tick(1, 0, 0);
      tick(0, 0, 0);
      tick(1, 0, 0);
      tick(0, 0, 0);
      tick(1, 0, 0);
      exp = 7'b1011111; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL block_entry2: got %b want %b", obs, exp); end
      tick(0, 0, 0);
      tick(0, 0, 0);
      tick(0, 0, 0);
      reset = 1'b1;
      tick(0, 0, 0);
      exp = 7'b0000000; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL reset_mid_block1: got %b want %b", obs, exp); end
      tick(0, 0, 0);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL reset_mid_block2: got %b want %b", obs, exp); end
      reset = 1'b0;
   endtask

   task automatic test_illegal();
      force dut.state_q = ill;
      tick(0, 0, 0);
      exp = 7'b1111011; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL illegal_outputs: got %b want %b", obs, exp); end
      release dut.state_q;
      tick(0, 0, 0);
      exp = 7'b1011011; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL illegal_to_bl: got %b want %b", obs, exp); end
      reset = 1'b1;
      tick(0, 0, 0);
      tick(0, 0, 0);
      reset = 1'b0;
   endtask

   task automatic test_random();
      logic b;
      reset = 1'b1;
      tick(0, 0, 0);
      tick(0, 0, 0);
      reset = 1'b0;
      b = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 2) == 0) b = ~b;
         reset = ($urandom_range(0, 149) == 0);
         tick(b, ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1);
         exp = {2'(m_mode), 2'(m_err), m_armed[0], m_bolt[0], m_alarm[0]};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL random_%0d: got %b want %b", i, obs, exp);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      m_mode = 0; m_err = 0; m_armed = 0; m_bolt = 0; m_alarm = 0;
      m_remain = 0; m_bprev = 0;
      @(negedge clk);
      test_reset();
      test_program();
      test_lock();
      test_lockout();
      test_unlock();
      test_hold();
      test_fecha_unprogrammed();
      test_reset_in_lockout();
      test_illegal();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
